// File: rtl/imem_pkg.sv
// Shared types for the fetch-side instruction line buffer: FSM states and the
// address split for the default 4-line x 4-word geometry.
package imem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } ibuf_state_t;

    localparam int LINE_WORDS_DEF = 4;
    localparam int NUM_LINES_DEF  = 4;
    localparam int OFFSET_W       = $clog2(LINE_WORDS_DEF);
    localparam int INDEX_W        = (NUM_LINES_DEF > 1) ? $clog2(NUM_LINES_DEF) : 1;
    localparam int TAG_W          = 30 - OFFSET_W - $clog2(NUM_LINES_DEF);

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
        logic [1:0]          byte_sel;
    } ibuf_addr_t;

endpackage

// File: rtl/ibuf_line_ram.sv
// Line data array: one synchronous write port and one synchronous read port
// whose registered output drives the fetch data bus directly.
module ibuf_line_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_data,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [31:0]   i_wr_data
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data_p1;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Stage p1: read data holds whenever no fetch hits
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data_p1 <= '0;
        end else if (i_rd_en) begin
            r_rd_data_p1 <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data_p1;

endmodule

// File: rtl/imem_line_buffer.sv
// Direct-mapped instruction line buffer with word-by-word refill over req/ack.
// Optional FENCE.I support (flush_i port) is enabled by defining IMEM_FLUSH_EN.
module imem_line_buffer
    import imem_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [31:0] imem_addr_i,
    input  logic        imem_rd_en_i,
`ifdef IMEM_FLUSH_EN
    input  logic        flush_i,
`endif
    output logic [31:0] imem_rdata_o,
    output logic        imem_valid_o,
    output logic        imem_stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int OFF_W    = $clog2(LINE_WORDS);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAGW     = 30 - OFF_W - IDX_BITS;
    localparam int RAM_AW   = OFF_W + IDX_BITS;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    ibuf_state_t           r_state;
    logic [NUM_LINES-1:0]  r_valid;
    logic [TAGW-1:0]       r_tag [NUM_LINES];
    logic [OFF_W-1:0]      r_beat;
    logic [IDX_W-1:0]      r_fill_idx;
    logic [TAGW-1:0]       r_fill_tag;
    logic                  r_flush_pend;
    logic                  r_mem_req;
    logic [31:0]           r_mem_addr;
    logic                  r_vld_p1;

    logic [OFF_W-1:0]      w_offset;
    logic [IDX_W-1:0]      w_index;
    logic [TAGW-1:0]       w_tag;
    logic [RAM_AW-1:0]     w_rd_addr;
    logic [RAM_AW-1:0]     w_wr_addr;
    logic                  w_flush;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_fill_wr;
    logic                  w_fill_done;
    logic                  w_unused;

`ifdef IMEM_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    assign w_offset = imem_addr_i[OFF_W+1:2];
    assign w_tag    = imem_addr_i[31 -: TAGW];
    assign w_unused = ^imem_addr_i[1:0];

    generate
        if (IDX_BITS > 0) begin : g_idx
            assign w_index   = imem_addr_i[OFF_W+2 +: IDX_BITS];
            assign w_rd_addr = {w_index, w_offset};
            assign w_wr_addr = {r_fill_idx, r_beat};
        end else begin : g_noidx
            assign w_index   = '0;
            assign w_rd_addr = w_offset;
            assign w_wr_addr = r_beat;
        end
    endgenerate

    // A flush in the same cycle as a request forces that request down the miss path
    assign w_hit = imem_rd_en_i && (r_state == IDLE) && !w_flush
                 && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss      = imem_rd_en_i && (r_state == IDLE) && !w_hit;
    assign w_fill_wr   = (r_state == REFILL) && mem_ack_i;
    assign w_fill_done = w_fill_wr && (r_beat == LAST_BEAT);

    assign imem_stall_o = !rst_i && ((r_state == REFILL) || w_miss);
    assign imem_valid_o = r_vld_p1;
    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_vld_p1     <= 1'b0;
        end else begin
            r_vld_p1 <= w_hit;
            case (r_state)
                IDLE: begin
                    if (w_flush) begin
                        r_valid <= '0;
                    end
                    if (w_miss) begin
                        r_valid[w_index] <= 1'b0;
                        r_beat           <= '0;
                        r_flush_pend     <= 1'b0;
                        r_mem_req        <= 1'b1;
                        r_mem_addr       <= {imem_addr_i[31:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
                        r_state          <= REFILL;
                    end
                end
                REFILL: begin
                    if (w_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_fill_done) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                        if (r_flush_pend || w_flush) begin
                            r_valid <= '0;
                        end else begin
                            r_valid[r_fill_idx] <= 1'b1;
                        end
                    end else if (w_fill_wr) begin
                        r_beat     <= r_beat + 1'b1;
                        r_mem_addr <= r_mem_addr + 32'd4;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss) begin
            r_fill_idx <= w_index;
            r_fill_tag <= w_tag;
        end
        if (w_fill_done) begin
            r_tag[r_fill_idx] <= r_fill_tag;
        end
    end

    ibuf_line_ram #(
        .DEPTH (LINE_WORDS * NUM_LINES),
        .AW    (RAM_AW)
    ) u_ram (
        .clk       (clk),
        .rst_i     (rst_i),
        .i_rd_en   (w_hit),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (imem_rdata_o),
        .i_wr_en   (w_fill_wr),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (mem_rdata_i)
    );

endmodule

// File: tb/tb_imem_line_buffer.sv
// Bench for imem_line_buffer: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of the line buffer.
module tb_imem_line_buffer;

    localparam int LW = 4;
    localparam int NL = 4;
    localparam int OW = $clog2(LW);
    localparam int IW = $clog2(NL);

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] imem_rdata_o;
    logic        imem_valid_o;
    logic        imem_stall_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    imem_line_buffer #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .imem_addr_i  (addr),
        .imem_rd_en_i (rd_en),
`ifdef IMEM_FLUSH_EN
        .flush_i      (flush),
`endif
        .imem_rdata_o (imem_rdata_o),
        .imem_valid_o (imem_valid_o),
        .imem_stall_o (imem_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Backing memory contents: 0x0 -> 0x13, 0x4 -> 0x93, 0x8 -> 0x113 ...
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h13 + ((a & ~32'h3) << 5);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> (2 + OW)) % NL);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (2 + OW + IW);
    endfunction

    // Model: per-index valid/tag plus a queue of word addresses still to fetch
    bit          mv [NL];
    logic [31:0] mt [NL];
    logic [31:0] pend [$];
    int          pidx = 0;
    logic [31:0] ptag = '0;
    bit          fpend = 1'b0;
    bit          e_valid = 1'b0;
    logic [31:0] e_rdata = '0;
    logic [31:0] e_addr = '0;

    function automatic bit m_hit(input logic [31:0] a);
        return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
    endfunction

    function automatic bit e_stall();
        return !rst_i && ((pend.size() != 0) || (rd_en && !(m_hit(addr) && !flush)));
    endfunction

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            foreach (mv[i]) mv[i] = 1'b0;
            pend.delete();
            fpend   = 1'b0;
            e_valid = 1'b0;
            e_rdata = '0;
            e_addr  = '0;
        end else if (pend.size() == 0) begin
            bit h;
            h = rd_en && m_hit(addr) && !flush;
            e_valid = h;
            if (h) e_rdata = word(addr);
            if (flush) foreach (mv[i]) mv[i] = 1'b0;
            if (rd_en && !h) begin
                mv[idx_of(addr)] = 1'b0;
                pidx  = idx_of(addr);
                ptag  = tag_of(addr);
                fpend = 1'b0;
                for (int k = 0; k < LW; k++)
                    pend.push_back((addr & ~32'(LW * 4 - 1)) + 32'(4 * k));
            end
        end else begin
            e_valid = 1'b0;
            if (flush) fpend = 1'b1;
            if (mem_ack_i) begin
                void'(pend.pop_front());
                if (pend.size() == 0) begin
                    if (fpend) foreach (mv[i]) mv[i] = 1'b0;
                    else begin
                        mv[pidx] = 1'b1;
                        mt[pidx] = ptag;
                    end
                end
            end
        end
        if (!rst_i && pend.size() != 0) e_addr = pend[0];
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'd0, imem_valid_o}, {31'd0, e_valid});
            chk("rdata", imem_rdata_o, e_rdata);
            chk("stall", {31'd0, imem_stall_o}, {31'd0, e_stall()});
            chk("req", {31'd0, mem_req_o}, {31'd0, (pend.size() != 0)});
            chk("maddr", mem_addr_o, e_addr);
        end
    end

    // Backing memory responder; mode 0 acks every 2nd request cycle, mode 1 acks at random
    int          amode = 0;
    bit          tg = 1'b0;
    logic [31:0] acks [$];

    always begin
        @(posedge clk);
        #1;
        mem_rdata_i = word(mem_addr_o);
        if (amode == 0) begin
            if (mem_req_o) tg = ~tg;
            else tg = 1'b0;
            mem_ack_i = mem_req_o && !tg;
        end else begin
            mem_ack_i = ($urandom_range(0, 1) == 1);
        end
        if (!rst_i && mem_req_o && mem_ack_i) acks.push_back(mem_addr_o);
    end

    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int nst);
        addr  = a;
        rd_en = 1'b1;
        nst   = 0;
        #1;
        while (imem_stall_o && nst < 200) begin
            nst++;
            @(posedge clk);
            #2;
        end
        chk("fetch_bound", {31'd0, (nst < 200)}, 32'd1);
        @(posedge clk);
        #2;
        d = imem_rdata_o;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          n;

        rd_en = 1'b1;
        #1 chk_en = 1'b1;
        chk("rst_valid", {31'd0, imem_valid_o}, 32'd0);
        chk("rst_rdata", imem_rdata_o, 32'd0);
        chk("rst_stall", {31'd0, imem_stall_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_maddr", mem_addr_o, 32'd0);
        rd_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Cold miss at 0x0
        @(posedge clk);
        #1 acks.delete();
        fetch(32'h0, d, n);
        chk("cold_stall_cycles", 32'(n), 32'd9);
        chk("cold_rdata", d, 32'h13);
        chk("cold_valid", {31'd0, imem_valid_o}, 32'd1);
        chk("cold_nacks", 32'(acks.size()), 32'd4);
        for (int i = 0; i < 4 && i < acks.size(); i++) chk("cold_maddr", acks[i], 32'(4 * i));

        // Hit streaming
        fetch(32'h4, d, n);
        chk("hit4_rdata", d, 32'h93);
        chk("hit4_stall", 32'(n), 32'd0);
        fetch(32'h8, d, n);
        chk("hit8_rdata", d, 32'h113);
        chk("hit8_stall", 32'(n), 32'd0);
        fetch(32'hC, d, n);
        chk("hitC_rdata", d, 32'h193);
        chk("hitC_stall", 32'(n), 32'd0);
        chk("hit_req", {31'd0, mem_req_o}, 32'd0);

        // Conflict eviction at index 0
        acks.delete();
        fetch(32'h40, d, n);
        chk("evict_rdata", d, 32'h813);
        fetch(32'h0, d, n);
        chk("evict_back_rdata", d, 32'h13);
        chk("evict_nacks", 32'(acks.size()), 32'd8);

        // Redirect during refill
        rd_en = 1'b0;
        pulse_reset();
        acks.delete();
        @(posedge clk);
        #1 addr = 32'h0;
        rd_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        fetch(32'h20, d, n);
        chk("redir_rdata", d, 32'h413);
        chk("redir_nacks", 32'(acks.size()), 32'd8);
        for (int i = 0; i < 8 && i < acks.size(); i++)
            chk("redir_maddr", acks[i], (i < 4) ? 32'(4 * i) : 32'(32'h20 + 4 * (i - 4)));
        fetch(32'h0, d, n);
        chk("redir_line0_stall", 32'(n), 32'd0);
        chk("redir_line0_rdata", d, 32'h13);

        // Reset in the middle of a refill
        rd_en = 1'b0;
        pulse_reset();
        acks.delete();
        @(posedge clk);
        #1 addr = 32'h0;
        rd_en = 1'b1;
        for (int i = 0; i < 100 && acks.size() < 2; i++) @(posedge clk);
        chk("mid_rst_acks_seen", 32'(acks.size()), 32'd2);
        @(posedge clk);
        #3 rst_i = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("mid_rst_stall", {31'd0, imem_stall_o}, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        acks.delete();
        fetch(32'h0, d, n);
        chk("post_rst_nacks", 32'(acks.size()), 32'd4);
        chk("post_rst_rdata", d, 32'h13);

`ifdef IMEM_FLUSH_EN
        // Flush in IDLE, then flush during a refill
        @(posedge clk);
        #2 rd_en = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        acks.delete();
        fetch(32'h0, d, n);
        chk("flush_refetch_nacks", 32'(acks.size()), 32'd4);
        chk("flush_refetch_rdata", d, 32'h13);
        acks.delete();
        addr  = 32'h40;
        rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        fetch(32'h40, d, n);
        chk("flush_mid_nacks", 32'(acks.size()), 32'd8);
        chk("flush_mid_rdata", d, 32'h813);
`endif

        // Random traffic with random ack timing
        @(posedge clk);
        #1 amode = 1;
        for (int c = 0; c < 600; c++) begin
            rd_en = ($urandom_range(0, 9) < 7);
            addr  = $urandom_range(0, 1023);
`ifdef IMEM_FLUSH_EN
            flush = ($urandom_range(0, 29) == 0);
`endif
            @(posedge clk);
            #1;
        end
        rd_en = 1'b0;
        flush = 1'b0;
        amode = 0;
        repeat (20) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
